// File: rtl/neuron_sched_pkg.sv
// Shared constants and state encoding for the neuron tick scheduler.
// Integer widths and the legacy-compatible FSM encoding live here so that datapath and scheduler agree.
package neuron_sched_pkg;

  localparam int NUM_NEURONS_DEFAULT = 256;
  localparam int NUM_AXONS_DEFAULT   = 256;
  localparam int POT_W               = 9;
  localparam int WT_SEL_W            = 2;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE      = 2'd0;
  localparam state_t S_LOAD      = 2'd1;
  localparam state_t S_INTEGRATE = 2'd2;
  localparam state_t S_COMMIT    = 2'd3;

  // Index width that stays at least one bit wide for degenerate single-entry configurations.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_scheduler.sv
// Tick scheduler that walks every neuron through LOAD, INTEGRATE over all axons, and COMMIT
// on a single shared neuron datapath, with a valid/ready handshake for outgoing spike events.
module neuron_scheduler
  import neuron_sched_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEFAULT,
  parameter int NUM_AXONS   = NUM_AXONS_DEFAULT,
  localparam int NIDX_W     = idx_w(NUM_NEURONS),
  localparam int AIDX_W     = idx_w(NUM_AXONS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [NIDX_W-1:0]          neuron_idx,
  output logic [AIDX_W-1:0]          axon_idx,
  input  logic                       axon_spike,
  input  logic [WT_SEL_W-1:0]        axon_type,
  input  logic                       synapse_conn,
  output logic                       new_neuron,
  output logic                       reg_en,
  output logic                       process_spike,
  output logic [WT_SEL_W-1:0]        neuron_instruction,
  input  logic                       dp_spike,
  input  logic signed [POT_W-1:0]    dp_potential,
  output logic                       pot_we,
  output logic signed [POT_W-1:0]    pot_wdata,
  output logic                       spike_valid,
  input  logic                       spike_ready,
  output logic [NIDX_W-1:0]          spike_neuron
);

  localparam logic [NIDX_W-1:0] LAST_NEURON = NIDX_W'(NUM_NEURONS - 1);
  localparam logic [AIDX_W-1:0] LAST_AXON   = AIDX_W'(NUM_AXONS - 1);

  state_t              state_q, state_d;
  logic [NIDX_W-1:0]   neuron_idx_q, neuron_idx_d;
  logic [AIDX_W-1:0]   axon_idx_q, axon_idx_d;
  logic                done_q, done_d;
  logic                in_integrate;
  logic                in_commit;
  logic                committed;

  assign in_integrate = (state_q == S_INTEGRATE);
  assign in_commit    = (state_q == S_COMMIT);

  // A neuron without a spike commits at once; a spiking one waits for the consumer.
  assign committed    = in_commit && (!dp_spike || spike_ready);

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case infers a latch.
    state_d      = state_q;
    neuron_idx_d = neuron_idx_q;
    axon_idx_d   = axon_idx_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_INTEGRATE;
      end
      S_INTEGRATE: begin
        if (axon_idx_q == LAST_AXON) begin
          state_d    = S_COMMIT;
          axon_idx_d = '0;
        end else begin
          axon_idx_d = axon_idx_q + AIDX_W'(1);
        end
      end
      S_COMMIT: begin
        if (committed) begin
          if (neuron_idx_q == LAST_NEURON) begin
            state_d      = S_IDLE;
            neuron_idx_d = '0;
            done_d       = 1'b1;
          end else begin
            state_d      = S_LOAD;
            neuron_idx_d = neuron_idx_q + NIDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      neuron_idx_q <= '0;
      axon_idx_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q      <= state_d;
      neuron_idx_q <= neuron_idx_d;
      axon_idx_q   <= axon_idx_d;
      done_q       <= done_d;
    end
  end

  assign busy               = (state_q != S_IDLE);
  assign done               = done_q;
  assign neuron_idx         = neuron_idx_q;
  assign axon_idx           = axon_idx_q;
  assign new_neuron         = (state_q == S_LOAD);
  assign reg_en             = in_integrate;
  assign process_spike      = in_integrate && axon_spike && synapse_conn;
  assign neuron_instruction = in_integrate ? axon_type : '0;
  assign spike_valid        = in_commit && dp_spike;
  assign spike_neuron       = neuron_idx_q;
  assign pot_we             = committed;
  assign pot_wdata          = dp_potential;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Bench for neuron_scheduler at 4 neurons x 4 axons, with a behavioural datapath (leak 0,
// threshold 30, reset potential 0) and potential memory wrapped around the scheduler.
module tb_neuron_scheduler;

  localparam int NN = 4;
  localparam int NA = 4;
  localparam logic signed [8:0] THRESH    = 9'sd30;
  localparam logic signed [8:0] RESET_POT = 9'sd0;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              busy, done;
  logic [1:0]        neuron_idx, axon_idx;
  logic              axon_spike;
  logic [1:0]        axon_type;
  logic              synapse_conn;
  logic              new_neuron, reg_en, process_spike;
  logic [1:0]        neuron_instruction;
  logic              dp_spike;
  logic signed [8:0] dp_potential;
  logic              pot_we;
  logic signed [8:0] pot_wdata;
  logic              spike_valid, spike_ready;
  logic [1:0]        spike_neuron;

  always #5 clk = ~clk;

  neuron_scheduler #(.NUM_NEURONS(NN), .NUM_AXONS(NA)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .neuron_idx(neuron_idx), .axon_idx(axon_idx), .axon_spike(axon_spike),
    .axon_type(axon_type), .synapse_conn(synapse_conn), .new_neuron(new_neuron),
    .reg_en(reg_en), .process_spike(process_spike), .neuron_instruction(neuron_instruction),
    .dp_spike(dp_spike), .dp_potential(dp_potential), .pot_we(pot_we), .pot_wdata(pot_wdata),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_neuron(spike_neuron)
  );

  // Spike buffer, weight types and crossbar seen by the scheduler.
  logic [3:0]        cur_spike;
  logic [7:0]        cur_types;
  logic [15:0]       cur_conn;
  logic signed [8:0] init_pot [NN];
  logic signed [8:0] pot_mem  [NN];
  logic              load_mem;
  logic signed [8:0] acc_q;

  assign axon_spike   = cur_spike[axon_idx];
  assign axon_type    = cur_types[{axon_idx, 1'b0} +: 2];
  assign synapse_conn = cur_conn[{neuron_idx, axon_idx}];

  function automatic logic signed [8:0] weight(input logic [1:0] sel);
    case (sel)
      2'd0:    return 9'sd10;
      2'd1:    return 9'sd3;
      2'd2:    return -9'sd4;
      default: return 9'sd1;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    acc_q <= 9'sd0;
    else if (new_neuron)             acc_q <= pot_mem[neuron_idx];
    else if (reg_en && process_spike) acc_q <= acc_q + weight(neuron_instruction);
  end

  assign dp_spike     = (acc_q >= THRESH);
  assign dp_potential = dp_spike ? RESET_POT : acc_q;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < NN; i++) pot_mem[i] <= init_pot[i];
    end else if (pot_we) begin
      pot_mem[neuron_idx] <= pot_wdata;
    end
  end

  typedef struct {
    string       name;
    logic [3:0]  spike;
    logic [7:0]  types;
    logic [15:0] conn;
    logic [35:0] pots;
    int          stall_c;
    int          exp_done;
    int          exp_ps;
    int          exp_hold;
    logic [3:0]  exp_spk;
    logic [35:0] exp_pots;
  } vec_t;

  vec_t vecs [5];
  int   n_checks = 0;
  int   n_errors = 0;

  int         done_cnt, done_cyc, busy_cnt, we_cnt, we_order_bad, ps_cnt, re_cnt, nn_cnt;
  int         ctrl_bad, hold_cnt, spk_order_bad, busy_after, last_spk;
  logic [3:0] spk_mask;

  function automatic logic [35:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {9'(a3), 9'(a2), 9'(a1), 9'(a0)};
  endfunction

  function automatic int out_bundle();
    return int'({busy, done, pot_we, spike_valid, new_neuron, reg_en, process_spike,
                 neuron_instruction, neuron_idx, axon_idx});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_state(input logic [3:0] sp, input logic [7:0] ty, input logic [15:0] cn,
                            input logic [35:0] p);
    @(negedge clk);
    cur_spike = sp;
    cur_types = ty;
    cur_conn  = cn;
    for (int i = 0; i < NN; i++) init_pot[i] = p[i*9 +: 9];
    load_mem = 1'b1;
    @(negedge clk);
    load_mem = 1'b0;
  endtask

  // Runs one tick, holding spike_ready low for stall_c cycles on neuron 1 and
  // re-pulsing start in cycle restart_cyc (cycle 1 is the first busy cycle).
  task automatic run_tick(input int stall_c, input int restart_cyc);
    int left, cyc, post;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; we_cnt = 0; we_order_bad = 0;
    ps_cnt = 0; re_cnt = 0; nn_cnt = 0; ctrl_bad = 0; hold_cnt = 0;
    spk_order_bad = 0; busy_after = -1; last_spk = -1; spk_mask = '0;
    left = stall_c;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1; post = -1;
    while (cyc < 200 && post != 0) begin
      spike_ready = !(spike_valid && neuron_idx == 2'd1 && left > 0);
      if (!spike_ready) left--;
      #1;
      if (busy) busy_cnt++;
      if (reg_en) re_cnt++;
      if (new_neuron) nn_cnt++;
      if (process_spike) ps_cnt++;
      if (spike_valid && neuron_idx == 2'd1) hold_cnt++;
      if (!reg_en && (process_spike || neuron_instruction != 2'd0)) ctrl_bad++;
      if (reg_en && (new_neuron || !busy)) ctrl_bad++;
      if (reg_en && (process_spike != (axon_spike && synapse_conn) || neuron_instruction != axon_type))
        ctrl_bad++;
      if (pot_we) begin
        if (int'(neuron_idx) != we_cnt) we_order_bad++;
        we_cnt++;
      end
      if (spike_valid && spike_ready) begin
        if (int'(spike_neuron) <= last_spk) spk_order_bad++;
        last_spk = int'(spike_neuron);
        spk_mask[spike_neuron] = 1'b1;
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) busy_after = int'(busy);
      if (done) begin
        done_cnt++;
        if (post < 0) begin
          done_cyc = cyc;
          post = 3;
        end
      end
      if (post > 0) post--;
      start = (cyc == restart_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    spike_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, we_rst, done_rst, busy_rst;
    logic signed [8:0] e;

    vecs[0] = '{"no_spikes",   4'h0, 8'h00, 16'hFFFF, pack4(5, -7, 20, 0),  0, 25, 0,  0, 4'b0000, pack4(5, -7, 20, 0)};
    vecs[1] = '{"all_spike",   4'hF, 8'h00, 16'hFFFF, pack4(0, 0, 0, 0),    0, 25, 16, 1, 4'b1111, pack4(0, 0, 0, 0)};
    vecs[2] = '{"backpress",   4'hF, 8'h00, 16'hFFFF, pack4(0, 0, 0, 0),    3, 28, 16, 4, 4'b1111, pack4(0, 0, 0, 0)};
    vecs[3] = '{"conn_mask",   4'hF, 8'hE4, 16'hFBFB, pack4(0, 0, 0, 25),   0, 25, 14, 0, 4'b1000, pack4(14, 10, 14, 0)};
    vecs[4] = '{"partial",     4'hA, 8'h55, 16'hFFFF, pack4(27, 28, 0, -100), 0, 25, 8, 1, 4'b0011, pack4(0, 0, 6, -94)};

    start = 1'b0; spike_ready = 1'b1; load_mem = 1'b0;
    cur_spike = '0; cur_types = '0; cur_conn = '0;
    for (int i = 0; i < NN; i++) init_pot[i] = 9'sd0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.outputs", out_bundle(), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset.idle_after_release", int'(busy), 0);

    for (int v = 0; v < 5; v++) begin
      load_state(vecs[v].spike, vecs[v].types, vecs[v].conn, vecs[v].pots);
      run_tick(vecs[v].stall_c, 0);
      check({vecs[v].name, ".done_count"},   done_cnt, 1);
      check({vecs[v].name, ".done_cycle"},   done_cyc, vecs[v].exp_done);
      check({vecs[v].name, ".busy_cycles"},  busy_cnt, vecs[v].exp_done - 1);
      check({vecs[v].name, ".pot_we_count"}, we_cnt, NN);
      check({vecs[v].name, ".pot_we_order"}, we_order_bad, 0);
      check({vecs[v].name, ".process_spike_cycles"}, ps_cnt, vecs[v].exp_ps);
      check({vecs[v].name, ".reg_en_cycles"}, re_cnt, NN * NA);
      check({vecs[v].name, ".new_neuron_cycles"}, nn_cnt, NN);
      check({vecs[v].name, ".control_decode"}, ctrl_bad, 0);
      check({vecs[v].name, ".commit_hold_n1"}, hold_cnt, vecs[v].exp_hold);
      check({vecs[v].name, ".spike_neurons"}, int'(spk_mask), int'(vecs[v].exp_spk));
      check({vecs[v].name, ".spike_order"},  spk_order_bad, 0);
      for (int i = 0; i < NN; i++) begin
        e = vecs[v].exp_pots[i*9 +: 9];
        check($sformatf("%s.pot%0d", vecs[v].name, i), int'(pot_mem[i]), int'(e));
      end
    end

    // start pulsed mid-tick must be ignored
    load_state(4'h0, 8'h00, 16'hFFFF, pack4(1, 2, 3, 4));
    run_tick(0, 5);
    check("ignore_start.done_count", done_cnt, 1);
    check("ignore_start.done_cycle", done_cyc, 25);
    check("ignore_start.pot_we_count", we_cnt, NN);
    check("ignore_start.busy_after_done", busy_after, 0);

    // start coinciding with done launches the next tick immediately
    run_tick(0, 25);
    check("restart.done_cycle", done_cyc, 25);
    check("restart.busy_after_done", busy_after, 1);
    k = 28;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("restart.second_done_cycle", k, 50);

    // reset in the middle of neuron 2's integration
    load_state(4'hF, 8'h55, 16'hFFFF, pack4(1, 2, 3, 4));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(reg_en && neuron_idx == 2'd2 && axon_idx == 2'd1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("midreset.reached_n2", int'(reg_en && neuron_idx == 2'd2), 1);
    reset_n = 1'b0;
    #1;
    check("midreset.outputs_immediate", out_bundle(), 0);
    we_rst = 0; done_rst = 0; busy_rst = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) reset_n = 1'b1;
      @(negedge clk);
      if (pot_we) we_rst++;
      if (done) done_rst++;
      if (busy) busy_rst++;
    end
    check("midreset.no_pot_we", we_rst, 0);
    check("midreset.no_done", done_rst, 0);
    check("midreset.stays_idle", busy_rst, 0);
    check("midreset.pot0", int'(pot_mem[0]), 13);
    check("midreset.pot1", int'(pot_mem[1]), 14);
    check("midreset.pot2_untouched", int'(pot_mem[2]), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
